// File: rtl/bsort_pkg.sv
// Shared types for the bubble-sort controller: FSM state encoding and the
// write-back data select encoding.
package bsort_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StRdA,
      StLdA,
      StLdB,
      StCmp,
      StWrLo,
      StWrHi,
      StNext,
      StDone
   } state_e;

   // Write-back mux select: which operand register drives memory write data.
   localparam logic WR_SEL_A = 1'b0;
   localparam logic WR_SEL_B = 1'b1;

endpackage

// File: rtl/bubble_sort_ctrl_if.sv
// Control/memory handshake bundle between the bubble-sort controller and its
// datapath (memory, operand registers, comparator) and host.
interface bubble_sort_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 3
);
   logic                  start;
   logic                  a_gt_b;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_rd_en;
   logic                  mem_wr_en;
   logic                  wr_sel;
   logic                  ld_a;
   logic                  ld_b;
   logic                  busy;
   logic                  done;

   // Controller side.
   modport master (
      input  start, a_gt_b,
      output mem_addr, mem_rd_en, mem_wr_en, wr_sel, ld_a, ld_b, busy, done
   );

   // Datapath/host side.
   modport slave (
      output start, a_gt_b,
      input  mem_addr, mem_rd_en, mem_wr_en, wr_sel, ld_a, ld_b, busy, done
   );
endinterface

// File: rtl/bsort_loop_cnt.sv
// Pass (p) and index (j) counters for the bubble sort loop nest.
// advance steps j, or wraps j to 0 and steps p at the end of a pass.
module bsort_loop_cnt #(
   parameter int unsigned N          = 8,
   parameter int unsigned ADDR_WIDTH = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  advance,
   output logic [ADDR_WIDTH-1:0] j,
   output logic                  end_of_pass,
   output logic                  last_pass
);

   localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(N - 2);

   logic [ADDR_WIDTH-1:0] p_q, p_d;
   logic [ADDR_WIDTH-1:0] j_q, j_d;

   // Pass ends once j reaches the last unsorted pair (N-2-p).
   assign end_of_pass = (j_q == (LastIdx - p_q));
   assign last_pass   = (p_q == LastIdx);
   assign j           = j_q;

   // Next-state for the loop counters.
   always_comb begin
      p_d = p_q;
      j_d = j_q;
      if (clear) begin
         p_d = '0;
         j_d = '0;
      end else if (advance) begin
         if (end_of_pass) begin
            p_d = p_q + ADDR_WIDTH'(1);
            j_d = '0;
         end else begin
            j_d = j_q + ADDR_WIDTH'(1);
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_q <= '0;
         j_q <= '0;
      end else begin
         p_q <= p_d;
         j_q <= j_d;
      end
   end

endmodule

// File: rtl/bubble_sort_ctrl.sv
// Control FSM for an in-place ascending bubble sort over a synchronous-read
// memory. Issues reads into operand registers A/B, checks the comparator flag
// and writes the pair back swapped when A > B (strict, so the sort is stable).
// Optional feature: define BSORT_EARLY_EXIT_EN to finish as soon as a full
// pass makes no swap; otherwise all N-1 passes run and no swap flag exists.
module bubble_sort_ctrl
   import bsort_pkg::*;
#(
   parameter int unsigned N          = 8,
   parameter int unsigned ADDR_WIDTH = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   bubble_sort_ctrl_if.master bus
);

   if (N < 2) begin : gen_n_check
      $error("bubble_sort_ctrl: N must be >= 2");
   end

   state_e                state_q, state_d;
   logic                  cnt_clear;
   logic                  cnt_advance;
   logic                  end_of_pass;
   logic                  last_pass;
   logic                  early_exit;
   logic [ADDR_WIDTH-1:0] j;
   logic [ADDR_WIDTH-1:0] j_plus1;

   assign j_plus1 = j + ADDR_WIDTH'(1);

   bsort_loop_cnt #(
      .N         (N),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_loop_cnt (
      .clk        (clk),
      .rst        (rst),
      .clear      (cnt_clear),
      .advance    (cnt_advance),
      .j          (j),
      .end_of_pass(end_of_pass),
      .last_pass  (last_pass)
   );

`ifdef BSORT_EARLY_EXIT_EN
   logic swapped_q, swapped_d;

   // Swap-seen flag: set by any write-back, cleared at sort start and pass wrap.
   always_comb begin
      swapped_d = swapped_q;
      if (state_q == StWrLo) begin
         swapped_d = 1'b1;
      end
      if (cnt_clear || (cnt_advance && end_of_pass)) begin
         swapped_d = 1'b0;
      end
   end

   // Swap-seen flag register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         swapped_q <= 1'b0;
      end else begin
         swapped_q <= swapped_d;
      end
   end

   assign early_exit = ~swapped_q;
`else
   assign early_exit = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and loop-counter control.
   always_comb begin
      state_d     = state_q;
      cnt_clear   = 1'b0;
      cnt_advance = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d   = StRdA;
               cnt_clear = 1'b1;
            end
         end
         StRdA:  state_d = StLdA;
         StLdA:  state_d = StLdB;
         StLdB:  state_d = StCmp;
         StCmp:  state_d = bus.a_gt_b ? StWrLo : StNext;
         StWrLo: state_d = StWrHi;
         StWrHi: state_d = StNext;
         StNext: begin
            if (!end_of_pass) begin
               cnt_advance = 1'b1;
               state_d     = StRdA;
            end else if (last_pass || early_exit) begin
               state_d = StDone;
            end else begin
               cnt_advance = 1'b1;
               state_d     = StRdA;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      bus.mem_addr  = '0;
      bus.mem_rd_en = 1'b0;
      bus.mem_wr_en = 1'b0;
      bus.wr_sel    = WR_SEL_A;
      bus.ld_a      = 1'b0;
      bus.ld_b      = 1'b0;
      bus.busy      = (state_q != StIdle);
      bus.done      = 1'b0;
      unique case (state_q)
         StRdA: begin
            bus.mem_rd_en = 1'b1;
            bus.mem_addr  = j;
         end
         StLdA: begin
            bus.ld_a      = 1'b1;
            bus.mem_rd_en = 1'b1;
            bus.mem_addr  = j_plus1;
         end
         StLdB: bus.ld_b = 1'b1;
         // Low slot takes the smaller value held in B.
         StWrLo: begin
            bus.mem_wr_en = 1'b1;
            bus.mem_addr  = j;
            bus.wr_sel    = WR_SEL_B;
         end
         StWrHi: begin
            bus.mem_wr_en = 1'b1;
            bus.mem_addr  = j_plus1;
            bus.wr_sel    = WR_SEL_A;
         end
         StDone: bus.done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Self-checking bench for bubble_sort_ctrl: models the memory, operand
// registers and comparator, and checks results against a plain bubble sort.
module tb_bubble_sort_ctrl;

   localparam int N  = 8;
   localparam int AW = 3;

   typedef logic [7:0] arr_t [N];

   logic clk = 1'b0;
   logic rst = 1'b1;

   bubble_sort_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

   bubble_sort_ctrl #(
      .N         (N),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Datapath model.
   logic [7:0] mem [N];
   logic [7:0] rd_data;
   logic [7:0] opa;
   logic [7:0] opb;
   arr_t       init_arr;
   logic       init_req = 1'b0;

   always @(posedge clk) begin
      if (init_req) begin
         for (int i = 0; i < N; i++) mem[i] <= init_arr[i];
      end else if (bus.mem_wr_en) begin
         mem[bus.mem_addr] <= bus.wr_sel ? opb : opa;
      end
      if (bus.mem_rd_en) rd_data <= mem[bus.mem_addr];
      if (bus.ld_a) opa <= rd_data;
      if (bus.ld_b) opb <= rd_data;
   end

   assign bus.a_gt_b = (opa > opb);

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return 64'({bus.busy, bus.done, bus.mem_rd_en, bus.mem_wr_en, bus.wr_sel,
                  bus.ld_a, bus.ld_b, bus.mem_addr});
   endfunction

   function automatic logic [63:0] pack_arr(input arr_t a);
      logic [63:0] v;
      for (int i = 0; i < N; i++) v[8*i +: 8] = a[i];
      return v;
   endfunction

   function automatic logic [63:0] pack_mem();
      logic [63:0] v;
      for (int i = 0; i < N; i++) v[8*i +: 8] = mem[i];
      return v;
   endfunction

   // Reference: textbook bubble sort counting compares and swaps.
   task automatic ref_sort(input arr_t in, output arr_t out, output int c, output int s);
      logic [7:0] t;
      bit         sw;
      out = in;
      c   = 0;
      s   = 0;
      for (int p = 0; p <= N - 2; p++) begin
         sw = 1'b0;
         for (int k = 0; k <= N - 2 - p; k++) begin
            c++;
            if (out[k] > out[k+1]) begin
               t        = out[k];
               out[k]   = out[k+1];
               out[k+1] = t;
               s++;
               sw       = 1'b1;
            end
         end
`ifdef BSORT_EARLY_EXIT_EN
         if (!sw) break;
`endif
      end
   endtask

   task automatic load(input arr_t a);
      @(negedge clk);
      init_arr = a;
      init_req = 1'b1;
      @(negedge clk);
      init_req = 1'b0;
   endtask

   // Observe from the current post-edge sample until done rises (bounded).
   task automatic wait_done(output int cyc, output int writes, output int bad);
      cyc    = 0;
      writes = 0;
      bad    = 0;
      while (!bus.done && cyc < 4000) begin
         if (bus.mem_wr_en) writes++;
         if (bus.mem_wr_en && bus.wr_sel && !(opa > opb)) bad++;
         if ((bus.ld_a && bus.ld_b) || (bus.mem_rd_en && bus.mem_wr_en) || !bus.busy) bad++;
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic run_sort(input string tag, input bit hold);
      arr_t in, exp_arr, exp2;
      int   c, s, c2, s2, cyc, writes, bad;
      for (int i = 0; i < N; i++) in[i] = mem[i];
      ref_sort(in, exp_arr, c, s);
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) bus.start = 1'b0;
      wait_done(cyc, writes, bad);
      check({tag, "_done_cycle"}, 64'(cyc), 64'(5 * c + 2 * s));
      check({tag, "_writes"}, 64'(writes), 64'(2 * s));
      check({tag, "_protocol"}, 64'(bad), 64'd0);
      check({tag, "_mem"}, pack_mem(), pack_arr(exp_arr));
      @(posedge clk);
      #1;
      check({tag, "_idle_after_done"}, 64'({bus.busy, bus.done}), 64'd0);
      if (hold) begin
         @(posedge clk);
         #1;
         check({tag, "_restart"}, 64'(bus.busy), 64'd1);
         bus.start = 1'b0;
         ref_sort(exp_arr, exp2, c2, s2);
         wait_done(cyc, writes, bad);
         check({tag, "_rerun_cycle"}, 64'(cyc), 64'(5 * c2 + 2 * s2));
         check({tag, "_rerun_mem"}, pack_mem(), pack_arr(exp_arr));
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      arr_t a;
      int   nw, cyc, saw_done;
      bus.start = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("reset_outs", outs(), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("idle_outs", outs(), 64'd0);

      // Ascending: no writes.
      for (int i = 0; i < N; i++) a[i] = 8'(i);
      load(a);
      run_sort("ascending", 1'b0);

      // Descending: every compare swaps.
      for (int i = 0; i < N; i++) a[i] = 8'(N - 1 - i);
      load(a);
      run_sort("descending", 1'b0);

      // Duplicates: equal pairs must not be written.
      a = '{8'd3, 8'd3, 8'd1, 8'd3, 8'd0, 8'd0, 8'd2, 8'd3};
      load(a);
      run_sort("dups", 1'b0);

      // Random data, some with heavy duplication.
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < N; i++) begin
            a[i] = (r < 2) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
         end
         load(a);
         run_sort($sformatf("rand%0d", r), 1'b0);
      end

      // Reset during WR_LO of the 5th compare on descending data.
      for (int i = 0; i < N; i++) a[i] = 8'(N - 1 - i);
      load(a);
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      nw  = 0;
      cyc = 0;
      saw_done = 0;
      while (cyc < 200) begin
         if (bus.mem_wr_en) nw++;
         if (nw == 9) break;
         @(posedge clk);
         #1;
         cyc++;
      end
      check("rst_at_wrlo_sel", 64'(bus.wr_sel), 64'd1);
      check("rst_at_wrlo_found", 64'(nw), 64'd9);
      rst = 1'b1;
      #1;
      check("rst_async_outs", outs(), 64'd0);
      @(posedge clk);
      #1;
      if (bus.done) saw_done = 1;
      check("rst_held_outs", outs(), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      if (bus.done) saw_done = 1;
      check("rst_no_done", 64'(saw_done), 64'd0);
      check("rst_partial_mem", pack_mem(),
            pack_arr('{8'd6, 8'd5, 8'd4, 8'd3, 8'd7, 8'd2, 8'd1, 8'd0}));
      run_sort("after_rst", 1'b0);

      // start held high throughout: one done, return to IDLE, then restart.
      for (int i = 0; i < N; i++) a[i] = 8'($urandom_range(0, 255));
      load(a);
      run_sort("hold_start", 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
